// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of an 8:1 mux select with a bounded hold time
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   req    in   [7:0] level requests, bit i = requester i
//   grant  out  [7:0] registered one-hot grant, zero when idle
//   sel    out  [2:0] registered mux select (index of current owner)
//   valid  out  high while grant is nonzero
//   switch out  one-cycle pulse in the first cycle of each new grant
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    localparam int HCW = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       switch
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    logic [0:0]     state_q, state_d;
    logic [7:0]     grant_q, grant_d;
    logic [2:0]     sel_q, sel_d;
    logic [2:0]     last_q, last_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic           valid_q, valid_d;
    logic           switch_q, switch_d;
    logic [7:0]     own_bit;
    logic [7:0]     cand;
    logic [2:0]     pick;
    logic           found;
    logic           do_grant;

    // First set bit of r scanning base+1, base+2, ... wrapping; base itself is checked last.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] idx;
        rr_pick = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = base + 3'(k);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        own_bit = 8'd1 << sel_q;
        // While granted, the current owner never competes in its own successor pick.
        cand = (state_q == GRANT) ? (req & ~own_bit) : req;
        {found, pick} = rr_pick(cand, last_q);
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        last_d   = last_q;
        hold_d   = hold_q;
        valid_d  = valid_q;
        switch_d = 1'b0;
        do_grant = 1'b0;
        if (state_q == IDLE) begin
            do_grant = found;
        end else if (!req[sel_q]) begin
            do_grant = found;
            if (!found) begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        end else if (hold_q == HCW'(MAX_HOLD)) begin
            // Limit reached: rotate if anyone else waits, otherwise renew silently.
            do_grant = found;
            if (!found) hold_d = HCW'(1);
        end else begin
            hold_d = hold_q + HCW'(1);
        end
        if (do_grant) begin
            state_d  = GRANT;
            grant_d  = 8'd1 << pick;
            sel_d    = pick;
            last_d   = pick;
            valid_d  = 1'b1;
            switch_d = 1'b1;
            hold_d   = HCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            last_q   <= 3'd7;
            hold_q   <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign valid  = valid_q;
    assign switch = switch_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and random checks of mux8_rr_arbiter against a behavioural model
module tb_mux8_rr_arbiter;
    localparam int MAX_HOLD = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       switch;
    int total = 0;
    int bad = 0;
    int m_owner = -1;
    int m_last = 7;
    int m_cnt = 0;
    int m_sel = 0;
    bit m_sw = 1'b0;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant), .sel(sel), .valid(valid), .switch(switch)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int excl);
        int i;
        for (int k = 1; k <= 8; k++) begin
            i = (m_last + k) % 8;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic give(input int p);
        m_owner = p;
        m_sel = p;
        m_last = p;
        m_cnt = 1;
        m_sw = 1'b1;
    endtask

    task automatic model(input logic [7:0] r, input logic rn);
        int p;
        m_sw = 1'b0;
        if (!rn) begin
            m_owner = -1;
            m_sel = 0;
            m_last = 7;
            m_cnt = 0;
        end else if (m_owner < 0) begin
            p = pick(r, -1);
            if (p >= 0) give(p);
        end else begin
            p = pick(r, m_owner);
            if (!r[m_owner]) begin
                if (p >= 0) give(p);
                else m_owner = -1;
            end else if (m_cnt == MAX_HOLD) begin
                if (p >= 0) give(p);
                else m_cnt = 1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rn);
        req = r;
        rst_n = rn;
        @(posedge clk);
        model(r, rn);
        #1;
        chk("grant", grant, m_owner < 0 ? 8'h00 : 8'(1 << m_owner));
        chk("sel", {5'b0, sel}, 8'(m_sel));
        chk("valid", {7'b0, valid}, {7'b0, m_owner >= 0});
        chk("switch", {7'b0, switch}, {7'b0, m_sw});
    endtask

    initial begin
        logic [7:0] r;
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        chk("reset_grant", grant, 8'h00);
        chk("reset_sel", {5'b0, sel}, 8'h00);
        step(8'h00, 1'b1);
        step(8'h08, 1'b1);
        chk("single_grant", grant, 8'h08);
        chk("single_switch", {7'b0, switch}, 8'h01);
        for (int i = 0; i < 10; i++) step(8'h08, 1'b1);
        chk("single_sel_held", {5'b0, sel}, 8'h03);
        step(8'h00, 1'b1);
        for (int i = 0; i < 40; i++) step(8'hFF, 1'b1);
        step(8'h00, 1'b1);
        step(8'h04, 1'b1);
        chk("early_owner2", grant, 8'h04);
        step(8'h24, 1'b1);
        step(8'h24, 1'b1);
        step(8'h20, 1'b1);
        chk("early_grant5", grant, 8'h20);
        chk("early_switch", {7'b0, switch}, 8'h01);
        step(8'h00, 1'b1);
        step(8'h21, 1'b1);
        chk("fair_grant0", grant, 8'h01);
        step(8'h00, 1'b1);
        step(8'h40, 1'b1);
        step(8'h40, 1'b1);
        step(8'h40, 1'b1);
        step(8'h40, 1'b0);
        chk("midreset_grant", grant, 8'h00);
        step(8'h41, 1'b1);
        chk("midreset_grant0", grant, 8'h01);
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom) & 8'($urandom) & ((i % 50 < 25) ? 8'hFF : 8'($urandom));
            step(r, ($urandom_range(0, 60) != 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
